// File: rtl/md_if.sv
// md_if: MIPS multiply/divide unit request/result bus (EX stage <-> md_unit)
interface md_if;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_mthi;
  logic        md_mtlo;
  logic        md_flush;
  logic        md_rd_hi;
  logic [31:0] md_rdata;
  logic        md_busy;
  logic        md_done;
  modport master (
    output md_start, md_op, md_src1, md_src2, md_mthi, md_mtlo, md_flush, md_rd_hi,
    input  md_rdata, md_busy, md_done
  );
  modport slave (
    input  md_start, md_op, md_src1, md_src2, md_mthi, md_mtlo, md_flush, md_rd_hi,
    output md_rdata, md_busy, md_done
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: HI/LO owner, 1-cycle MULT/MULTU, 33-cycle restoring DIV/DIVU; MD_DIV_EARLY_EN enables early finish when |dividend| < |divisor|
module md_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);
  localparam int CW = $clog2(DIV_ITER);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;
  logic [31:0] hi, lo, a_r, b_r;
  logic [32:0] rem_r, rem_sh, rem_nx;
  logic [CW-1:0] cnt;
  logic sgn, neg_q, neg_r, done_r;
  logic accept, is_mul, mt_ok, wr, ge, early, s1, s2;
  logic [31:0] amag, bmag, q_f, r_f;
  logic [63:0] prod;
  assign is_mul = bus.md_op[0] | bus.md_op[1];
  assign accept = state == IDLE && bus.md_start && !bus.md_flush && $onehot(bus.md_op);
  assign mt_ok = state == IDLE && !bus.md_flush && !accept;
  assign wr = !bus.md_flush && (state == MUL || state == FIX);
  assign s1 = bus.md_op[2] & bus.md_src1[31];
  assign s2 = bus.md_op[2] & bus.md_src2[31];
  assign amag = s1 ? -bus.md_src1 : bus.md_src1;
  assign bmag = s2 ? -bus.md_src2 : bus.md_src2;
`ifdef MD_DIV_EARLY_EN
  assign early = |bmag && amag < bmag;
`else
  assign early = 1'b0;
`endif
  assign rem_sh = {rem_r[31:0], a_r[31]};
  assign ge = rem_sh >= {1'b0, b_r};
  assign rem_nx = ge ? rem_sh - {1'b0, b_r} : rem_sh;
  assign q_f = neg_q ? -a_r : a_r;
  assign r_f = neg_r ? -rem_r[31:0] : rem_r[31:0];
  assign prod = {{32{sgn & a_r[31]}}, a_r} * {{32{sgn & b_r[31]}}, b_r};
  assign bus.md_rdata = bus.md_rd_hi ? hi : lo;
  assign bus.md_busy = state != IDLE;
  assign bus.md_done = done_r;
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state; flush returns to IDLE from anywhere
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = is_mul ? MUL : (early ? FIX : DIV);
      MUL: nxt = IDLE;
      DIV: if (cnt == CW'(DIV_ITER - 1)) nxt = FIX;
      FIX: nxt = IDLE;
    endcase
    if (bus.md_flush) nxt = IDLE;
  end
  // operand latch, divider iteration and HI/LO update
  always_ff @(posedge clk)
    if (reset) begin
      hi <= '0;
      lo <= '0;
      a_r <= '0;
      b_r <= '0;
      rem_r <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= wr;
      if (accept) begin
        a_r <= is_mul ? bus.md_src1 : (early ? '0 : amag);
        b_r <= is_mul ? bus.md_src2 : bmag;
        rem_r <= early ? {1'b0, amag} : '0;
        cnt <= '0;
        sgn <= bus.md_op[0];
        neg_q <= s1 ^ s2;
        neg_r <= s1;
      end else if (state == DIV) begin
        a_r <= {a_r[30:0], ge};
        rem_r <= rem_nx;
        cnt <= cnt + 1'b1;
      end
      if (wr) {hi, lo} <= state == MUL ? prod : {r_f, q_f};
      if (mt_ok && bus.md_mthi) hi <= bus.md_src1;
      if (mt_ok && bus.md_mtlo) lo <= bus.md_src1;
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  md_if bus();
  md_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef MD_DIV_EARLY_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    bus.md_rd_hi = 1'b1;
    #1;
    check({tag, " hi"}, 64'(bus.md_rdata), 64'(ehi));
    bus.md_rd_hi = 1'b0;
    #1;
    check({tag, " lo"}, 64'(bus.md_rdata), 64'(elo));
  endtask
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bus.md_start = 1'b1;
    bus.md_op = op;
    bus.md_src1 = a;
    bus.md_src2 = b;
    tick();
    bus.md_start = 1'b0;
    n = 0;
    while (bus.md_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, " busy cycles"}, 64'(n), 64'(lat));
    check({tag, " done"}, 64'(bus.md_done), 64'd1);
    chk_hilo(tag, ehi, elo);
    tick();
    check({tag, " done drop"}, 64'(bus.md_done), 64'd0);
  endtask
  initial begin
    bus.md_start = 1'b0;
    bus.md_op = 4'b0;
    bus.md_src1 = '0;
    bus.md_src2 = '0;
    bus.md_mthi = 1'b0;
    bus.md_mtlo = 1'b0;
    bus.md_flush = 1'b0;
    bus.md_rd_hi = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", 64'(bus.md_busy), 64'd0);
    check("reset done", 64'(bus.md_done), 64'd0);
    chk_hilo("reset", 32'h0, 32'h0);
    do_op("mult", 4'b0001, 32'hFFFFFFFE, 32'h00000003, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("multu", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult neg*neg", 4'b0001, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000);
    do_op("divu 100/7", 4'b1000, 32'd100, 32'd7, 33, 32'h00000002, 32'h0000000E);
    do_op("div -100/7", 4'b0100, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFFE, 32'hFFFFFFF2);
    do_op("div 100/-7", 4'b0100, 32'd100, 32'hFFFFFFF9, 33, 32'h00000002, 32'hFFFFFFF2);
    do_op("div min/-1", 4'b0100, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    do_op("divu x/0", 4'b1000, 32'h12345678, 32'h0, 33, 32'h12345678, 32'hFFFFFFFF);
    do_op("div neg/0", 4'b0100, 32'hFFFFFFF6, 32'h0, 33, 32'hFFFFFFF6, 32'h00000001);
    do_op("div pos/0", 4'b0100, 32'h00000005, 32'h0, 33, 32'h00000005, 32'hFFFFFFFF);
    do_op("divu 3/9", 4'b1000, 32'd3, 32'd9, EARLY_LAT, 32'h00000003, 32'h00000000);
    do_op("div -3/9", 4'b0100, 32'hFFFFFFFD, 32'd9, EARLY_LAT, 32'hFFFFFFFD, 32'h00000000);
    bus.md_mthi = 1'b1;
    bus.md_src1 = 32'hAABBCCDD;
    tick();
    bus.md_mthi = 1'b0;
    chk_hilo("mthi", 32'hAABBCCDD, 32'h00000000);
    bus.md_mtlo = 1'b1;
    bus.md_src1 = 32'h11223344;
    tick();
    bus.md_mtlo = 1'b0;
    chk_hilo("mtlo", 32'hAABBCCDD, 32'h11223344);
    bus.md_mthi = 1'b1;
    bus.md_mtlo = 1'b1;
    bus.md_src1 = 32'h55555555;
    tick();
    bus.md_mthi = 1'b0;
    bus.md_mtlo = 1'b0;
    chk_hilo("mthi+mtlo", 32'h55555555, 32'h55555555);
    bus.md_start = 1'b1;
    bus.md_op = 4'b0100;
    bus.md_src1 = 32'd100;
    bus.md_src2 = 32'd7;
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("flush pre busy", 64'(bus.md_busy), 64'd1);
    bus.md_flush = 1'b1;
    bus.md_mthi = 1'b1;
    bus.md_src1 = 32'hDEADBEEF;
    tick();
    bus.md_flush = 1'b0;
    bus.md_mthi = 1'b0;
    check("flush busy", 64'(bus.md_busy), 64'd0);
    check("flush done", 64'(bus.md_done), 64'd0);
    chk_hilo("flush", 32'h55555555, 32'h55555555);
    for (int i = 0; i < 30; i++) tick();
    check("flush late done", 64'(bus.md_done), 64'd0);
    check("flush late busy", 64'(bus.md_busy), 64'd0);
    chk_hilo("flush late", 32'h55555555, 32'h55555555);
    bus.md_start = 1'b1;
    bus.md_flush = 1'b1;
    bus.md_op = 4'b0001;
    tick();
    bus.md_start = 1'b0;
    bus.md_flush = 1'b0;
    check("flush blocks start", 64'(bus.md_busy), 64'd0);
    bus.md_start = 1'b1;
    bus.md_op = 4'b0011;
    bus.md_src1 = 32'd2;
    bus.md_src2 = 32'd3;
    tick();
    bus.md_start = 1'b0;
    check("bad op busy", 64'(bus.md_busy), 64'd0);
    tick();
    check("bad op done", 64'(bus.md_done), 64'd0);
    chk_hilo("bad op", 32'h55555555, 32'h55555555);
    bus.md_start = 1'b1;
    bus.md_op = 4'b1000;
    bus.md_src1 = 32'd100;
    bus.md_src2 = 32'd7;
    tick();
    bus.md_start = 1'b0;
    tick();
    bus.md_mtlo = 1'b1;
    bus.md_src1 = 32'h00000999;
    tick();
    bus.md_mtlo = 1'b0;
    check("mtlo busy", 64'(bus.md_busy), 64'd1);
    chk_hilo("mtlo busy", 32'h55555555, 32'h55555555);
    for (int i = 0; i < 40 && bus.md_busy === 1'b1; i++) tick();
    chk_hilo("after mtlo busy", 32'h00000002, 32'h0000000E);
    bus.md_start = 1'b1;
    bus.md_op = 4'b0100;
    bus.md_src1 = 32'd1000;
    bus.md_src2 = 32'd3;
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("pre reset busy", 64'(bus.md_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset busy", 64'(bus.md_busy), 64'd0);
    check("mid reset done", 64'(bus.md_done), 64'd0);
    chk_hilo("mid reset", 32'h0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It is the producer of the HI/LO result that the ID-stage bypass network consumes as EX_MD_data.
- Runs MULT/MULTU in 1 cycle and DIV/DIVU in 33 cycles (iterative restoring divider).
- Owns the architectural HI/LO registers and serves MTHI/MTLO writes and MFHI/MFLO reads.
- Exposes busy so hazard logic stalls ID/EX while an operation is in flight.

Parameters:
- DIV_ITER, 32, number of restoring-division iterations (operand width); fixed at 32 for MIPS32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- md_start  in  1  EX instruction is MULT/MULTU/DIV/DIVU and EX is allowed to proceed
- md_op  in  4  one-hot: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU
- md_src1  in  32  rs value
- md_src2  in  32  rt value
- md_mthi  in  1  write md_src1 into HI
- md_mtlo  in  1  write md_src1 into LO
- md_flush  in  1  exception/eret flush; abort current operation
- md_rd_hi  in  1  read select: 1 = HI (MFHI), 0 = LO (MFLO)
- md_rdata  out  32  selected HI/LO value (EX_MD_data)
- md_busy  out  1  operation in flight
- md_done  out  1  one-cycle pulse, HI/LO updated on the previous edge

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: HI=0, LO=0, state=IDLE, counter=0, md_busy=0, md_done=0.
- md_rdata: combinational mux of the HI/LO registers, never of in-flight values. md_busy = (state != IDLE).
- States:
  - IDLE: start accepted when md_start && !md_flush. MULT/MULTU goes to MUL. DIV/DIVU latches operand magnitudes and sign flags, clears the counter and goes to DIV.
  - MUL: performs a 32x32 -> 64 product (signed for MULT, unsigned for MULTU). Edge writes HI=product[63:32], LO=product[31:0]; next state IDLE. md_done=1 in the following cycle.
  - DIV: one restoring step per cycle on the 33-bit partial remainder. Counter increments 0..31; at count 31 the next state is FIX.
  - FIX: applies signs (DIV only). Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Edge writes LO=quotient, HI=remainder; next state IDLE; md_done pulses the next cycle.
- Latency, start accepted on edge E0:
  - MUL: md_busy high 1 cycle; HI/LO written at E1.
  - DIV: md_busy high 33 cycles; HI/LO written at E33.
- Division boundary results:
  - x/0 on DIVU: LO=FFFFFFFF, HI=x.
  - x/0 on DIV: HI=x, LO=(x<0 ? 00000001 : FFFFFFFF).
  - 80000000/FFFFFFFF on DIV: LO=80000000, HI=00000000.
- md_start while busy: ignored. Pipeline stall logic guarantees this does not occur.
- md_mthi/md_mtlo:
  - Take effect at the edge only when state=IDLE and no start is accepted in the same cycle.
  - Dropped while busy.
  - mthi and mtlo asserted together write both.
- md_flush:
  - Highest priority: from any state, next state IDLE with no HI/LO write and no md_done.
  - Also blocks a same-cycle start, mthi and mtlo.
- Reset asserted mid-operation: immediate return to reset values on that edge.
- md_op not one-hot while md_start=1: no operation is started, state stays IDLE, HI/LO are unchanged.

Optional Feature:
- Macro: MD_DIV_EARLY_EN.
- When defined: if on DIV/DIVU accept the divisor magnitude is non-zero and the dividend magnitude < divisor magnitude, the unit goes straight from IDLE to FIX. Quotient=0, remainder=dividend magnitude (then sign-fixed). md_busy is high 1 cycle and HI/LO are written at E1.
- When not defined: every division takes the full 33-cycle path.
- Results are identical either way; only latency differs.

Test Plan:
- reset, then MULT src1=FFFFFFFE (-2), src2=00000003 -> HI=FFFFFFFF, LO=FFFFFFFA at E1, md_busy high exactly 1 cycle, md_done pulses once.
- DIVU 00000064/00000007 -> LO=0000000E, HI=00000002 at E33, md_busy high 33 cycles; with MD_DIV_EARLY_EN the same result at E33.
- DIV FFFFFF9C (-100)/00000007 -> LO=FFFFFFF2 (-14), HI=FFFFFFFE (-2); DIV 80000000/FFFFFFFF -> LO=80000000, HI=0; DIVU 12345678/0 -> LO=FFFFFFFF, HI=12345678.
- DIVU 00000003/00000009 with MD_DIV_EARLY_EN -> LO=0, HI=3 at E1; without the macro the same values at E33.
- Start DIV, assert md_flush at cycle 10 -> md_busy drops next cycle, HI/LO keep prior values, no md_done; mthi in that same flush cycle is ignored.
- mthi AABBCCDD in IDLE, md_rd_hi=1 -> md_rdata=AABBCCDD next cycle; mtlo asserted while busy -> LO unchanged; reset asserted at DIV cycle 20 -> HI=LO=0, md_busy=0 next cycle.
